// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Definitions shared by the I2S output path.
//   fmt_e    : frame format select (FMT_I2S = Philips, FMT_LJ = left-justified)
//   frame_w  : SCK periods per stereo frame for a given sample width
// ---------------------------------------------------------------------------
package i2s_pkg;

    typedef enum logic {
        FMT_I2S = 1'b0,
        FMT_LJ  = 1'b1
    } fmt_e;

    function automatic int unsigned frame_w(input int unsigned sample_w);
        return 2 * sample_w;
    endfunction

endpackage

// File: rtl/i2so_sync_fifo.sv
// ---------------------------------------------------------------------------
// i2so_sync_fifo
// Single-clock FIFO with ready-to-send / ready-to-receive handshakes on both
// sides. The read data is taken from registered storage, so a word written
// in one cycle can be read no earlier than the next cycle.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_in_rts / o_in_rtr     write request / space available (!full)
//   i_in_data               write data
//   o_out_rts / i_out_rtr   data available (!empty) / read request
//   o_out_data              word at the head of the FIFO
//   o_level                 words currently stored (0 .. 2^AW)
//   o_full, o_empty         status
// ---------------------------------------------------------------------------
module i2so_sync_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_rts,
    output logic              o_in_rtr,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_rts,
    input  logic              i_out_rtr,
    output logic [DATA_W-1:0] o_out_data,
    output logic [AW:0]       o_level,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned DEPTH    = 2 ** AW;
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [AW:0]       r_level;
    logic              w_push;
    logic              w_pop;

    always_comb begin
        o_full     = (r_level == LVL_FULL);
        o_empty    = (r_level == '0);
        o_in_rtr   = ~o_full;
        o_out_rts  = ~o_empty;
        o_level    = r_level;
        o_out_data = r_mem[r_rd];
        w_push     = i_in_rts & ~o_full;
        w_pop      = i_out_rtr & ~o_empty;
    end

    // Storage carries no reset; validity is tracked by the pointers/level.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_in_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_out_param.sv
// ---------------------------------------------------------------------------
// i2s_out_param
// I2S transmitter: buffers {left, right} words from the filter in a FIFO and
// shifts them out MSB first on WS/SD, advancing one bit per sck_transition.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   sck_transition                one-clk pulse per SCK falling edge
//   cfg_en, cfg_fmt, cfg_mono     enable, format (0 I2S / 1 LJ), mono
//   filt_rts / filt_rtr           filter word handshake
//   filt_data                     {left, right} sample word
//   i2so_ws, i2so_sd              serial outputs (registered)
//   fifo_level                    words currently buffered
//   trig_fifo_underrun/_overrun   clear pulses for the sticky flags
//   ro_fifo_underrun/_overrun     sticky status flags
// ---------------------------------------------------------------------------
module i2s_out_param
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned FIFO_AW  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sck_transition,
    input  logic                    cfg_en,
    input  logic                    cfg_fmt,
    input  logic                    cfg_mono,
    input  logic                    filt_rts,
    output logic                    filt_rtr,
    input  logic [2*SAMPLE_W-1:0]   filt_data,
    output logic                    i2so_ws,
    output logic                    i2so_sd,
    output logic [FIFO_AW:0]        fifo_level,
    input  logic                    trig_fifo_underrun,
    input  logic                    trig_fifo_overrun,
    output logic                    ro_fifo_underrun,
    output logic                    ro_fifo_overrun
);

    localparam int unsigned   FW      = frame_w(SAMPLE_W);
    localparam int unsigned   CW      = $clog2(FW);
    localparam logic [CW-1:0] CNT_MAX = CW'(FW - 1);
    localparam logic [CW-1:0] HALF    = CW'(SAMPLE_W);

    logic [CW-1:0]  r_cnt;
    logic [FW-1:0]  r_frame;
    fmt_e           r_fmt;
    logic           r_sd;
    logic           r_ws;
    logic           r_ur;
    logic           r_or;

    logic           w_fifo_rts;
    logic [FW-1:0]  w_fifo_data;
    logic           w_full;
    logic           w_empty;
    logic           w_load;
    logic           w_pop;
    logic [CW-1:0]  w_cnt_nxt;
    logic [CW-1:0]  w_idx;
    logic [FW-1:0]  w_load_word;
    logic [FW-1:0]  w_frame_nxt;
    fmt_e           w_fmt_nxt;
    logic           w_sd_nxt;
    logic           w_ws_nxt;

    // In I2S format WS looks one bit ahead so it switches one SCK before
    // the MSB of the slot; left-justified switches with the MSB itself.
    function automatic logic ws_for(input logic [CW-1:0] c, input fmt_e f);
        logic [CW-1:0] ahead;
        ahead = (c == CNT_MAX) ? '0 : c + CW'(1);
        return (f == FMT_LJ) ? (c >= HALF) : (ahead >= HALF);
    endfunction

    i2so_sync_fifo #(
        .DATA_W (FW),
        .AW     (FIFO_AW)
    ) u_fifo (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_in_rts   (filt_rts),
        .o_in_rtr   (filt_rtr),
        .i_in_data  (filt_data),
        .o_out_rts  (w_fifo_rts),
        .i_out_rtr  (w_pop),
        .o_out_data (w_fifo_data),
        .o_level    (fifo_level),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_comb begin
        w_load    = cfg_en & sck_transition & (r_cnt == CNT_MAX);
        w_pop     = w_load & w_fifo_rts;
        w_cnt_nxt = (r_cnt == CNT_MAX) ? '0 : r_cnt + CW'(1);

        if (w_empty) begin
            w_load_word = '0;
        end else if (cfg_mono) begin
            w_load_word = {w_fifo_data[FW-1:SAMPLE_W], w_fifo_data[FW-1:SAMPLE_W]};
        end else begin
            w_load_word = w_fifo_data;
        end

        w_frame_nxt = w_load ? w_load_word : r_frame;
        w_fmt_nxt   = w_load ? fmt_e'(cfg_fmt) : r_fmt;
        w_idx       = CNT_MAX - w_cnt_nxt;
        w_sd_nxt    = w_frame_nxt[w_idx];
        w_ws_nxt    = ws_for(w_cnt_nxt, w_fmt_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= CNT_MAX;
            r_frame <= '0;
            r_fmt   <= FMT_I2S;
            r_sd    <= 1'b0;
            r_ws    <= 1'b0;
            r_ur    <= 1'b0;
            r_or    <= 1'b0;
        end else begin
            if (!cfg_en) begin
                // Parking the counter at the last bit makes the first SCK
                // after re-enable load a fresh frame.
                r_cnt   <= CNT_MAX;
                r_frame <= '0;
                r_sd    <= 1'b0;
                r_ws    <= 1'b0;
            end else if (sck_transition) begin
                r_cnt   <= w_cnt_nxt;
                r_frame <= w_frame_nxt;
                r_fmt   <= w_fmt_nxt;
                r_sd    <= w_sd_nxt;
                r_ws    <= w_ws_nxt;
            end

            // Set wins over a coincident clear.
            if (w_load && w_empty) begin
                r_ur <= 1'b1;
            end else if (trig_fifo_underrun) begin
                r_ur <= 1'b0;
            end

            if (filt_rts && w_full) begin
                r_or <= 1'b1;
            end else if (trig_fifo_overrun) begin
                r_or <= 1'b0;
            end
        end
    end

    always_comb begin
        i2so_sd          = r_sd;
        i2so_ws          = r_ws;
        ro_fifo_underrun = r_ur;
        ro_fifo_overrun  = r_or;
    end

endmodule

// File: tb/tb_i2s_out_param.sv
// ---------------------------------------------------------------------------
// tb_i2s_out_param
// Self-checking bench for i2s_out_param (SAMPLE_W = 16, FIFO_AW = 3).
// A queue-based reference model tracks the FIFO contents, the bit position in
// the current frame and the sticky flags; every cycle the DUT outputs are
// compared against it. Directed scenarios add hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_i2s_out_param;

    localparam int W     = 16;
    localparam int FW    = 32;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck_transition;
    logic        cfg_en;
    logic        cfg_fmt;
    logic        cfg_mono;
    logic        filt_rts;
    logic        filt_rtr;
    logic [31:0] filt_data;
    logic        i2so_ws;
    logic        i2so_sd;
    logic [3:0]  fifo_level;
    logic        trig_fifo_underrun;
    logic        trig_fifo_overrun;
    logic        ro_fifo_underrun;
    logic        ro_fifo_overrun;

    i2s_out_param #(
        .SAMPLE_W (16),
        .FIFO_AW  (3)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .sck_transition     (sck_transition),
        .cfg_en             (cfg_en),
        .cfg_fmt            (cfg_fmt),
        .cfg_mono           (cfg_mono),
        .filt_rts           (filt_rts),
        .filt_rtr           (filt_rtr),
        .filt_data          (filt_data),
        .i2so_ws            (i2so_ws),
        .i2so_sd            (i2so_sd),
        .fifo_level         (fifo_level),
        .trig_fifo_underrun (trig_fifo_underrun),
        .trig_fifo_overrun  (trig_fifo_overrun),
        .ro_fifo_underrun   (ro_fifo_underrun),
        .ro_fifo_overrun    (ro_fifo_overrun)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_on  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_q[$];
    logic [31:0] m_frame = '0;
    int          m_pos   = FW - 1;   // bit index within frame, MSB = 0
    bit          m_lj    = 1'b0;
    bit          m_sd    = 1'b0;
    bit          m_ws    = 1'b0;
    bit          m_ur    = 1'b0;
    bit          m_or    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_frame = '0;
            m_pos   = FW - 1;
            m_lj    = 1'b0;
            m_sd    = 1'b0;
            m_ws    = 1'b0;
            m_ur    = 1'b0;
            m_or    = 1'b0;
        end else begin
            bit          was_full;
            bit          was_empty;
            bit          ur_set;
            bit          or_set;
            logic [31:0] w;
            was_full  = (m_q.size() == DEPTH);
            was_empty = (m_q.size() == 0);
            ur_set    = 1'b0;
            or_set    = filt_rts && was_full;
            if (!cfg_en) begin
                m_pos   = FW - 1;
                m_frame = '0;
                m_sd    = 1'b0;
                m_ws    = 1'b0;
            end else if (sck_transition) begin
                if (m_pos == FW - 1) begin
                    m_pos = 0;
                    m_lj  = cfg_fmt;
                    if (was_empty) begin
                        m_frame = '0;
                        ur_set  = 1'b1;
                    end else begin
                        w       = m_q.pop_front();
                        m_frame = cfg_mono ? {w[31:16], w[31:16]} : w;
                    end
                end else begin
                    m_pos++;
                end
                m_sd = m_frame[FW - 1 - m_pos];
                m_ws = m_lj ? (m_pos >= W) : (((m_pos + 1) % FW) >= W);
            end
            if (filt_rts && !was_full) begin
                m_q.push_back(filt_data);
            end
            if (ur_set) m_ur = 1'b1;
            else if (trig_fifo_underrun) m_ur = 1'b0;
            if (or_set) m_or = 1'b1;
            else if (trig_fifo_overrun) m_or = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_sd",       32'(i2so_sd),          32'(m_sd));
            chk("cyc_ws",       32'(i2so_ws),          32'(m_ws));
            chk("cyc_level",    32'(fifo_level),       32'(m_q.size()));
            chk("cyc_rtr",      32'(filt_rtr),         32'(m_q.size() < DEPTH));
            chk("cyc_underrun", 32'(ro_fifo_underrun), 32'(m_ur));
            chk("cyc_overrun",  32'(ro_fifo_overrun),  32'(m_or));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        filt_data = d;
        filt_rts  = 1'b1;
        tick();
        filt_rts  = 1'b0;
    endtask

    // One SCK period = 4 clk; outputs are sampled right after the pulse edge.
    task automatic sck_step(input logic tu, output logic sd, output logic ws);
        sck_transition     = 1'b1;
        trig_fifo_underrun = tu;
        tick();
        sck_transition     = 1'b0;
        trig_fifo_underrun = 1'b0;
        sd = i2so_sd;
        ws = i2so_ws;
        repeat (3) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        s;
        logic        w;
        logic [31:0] sdv;
        logic [31:0] wsv;

        rst = 1'b1;
        sck_transition = 1'b0; cfg_en = 1'b0; cfg_fmt = 1'b0; cfg_mono = 1'b0;
        filt_rts = 1'b0; filt_data = '0;
        trig_fifo_underrun = 1'b0; trig_fifo_overrun = 1'b0;
        repeat (2) tick();
        chk_on = 1'b1;
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_rtr",   32'(filt_rtr),   32'd1);
        chk("rst_sd",    32'(i2so_sd),    32'd0);
        chk("rst_ws",    32'(i2so_ws),    32'd0);
        rst = 1'b0;
        tick();

        // Philips I2S
        push_word(32'hA5A5_3C3C);
        chk("i2s_level_before", 32'(fifo_level), 32'd1);
        cfg_fmt = 1'b0; cfg_en = 1'b1;
        sdv = '0; wsv = '0;
        for (int i = 0; i < FW; i++) begin
            sck_step(1'b0, s, w);
            sdv[FW - 1 - i] = s;
            wsv[i] = w;
            if (i == 0) chk("i2s_level_after_load", 32'(fifo_level), 32'd0);
        end
        chk("i2s_sd_word", sdv, 32'hA5A5_3C3C);
        chk("i2s_ws_mask", wsv, 32'h7FFF_8000);
        chk("i2s_no_underrun", 32'(ro_fifo_underrun), 32'd0);

        // Left-justified
        cfg_en = 1'b0;
        tick();
        push_word(32'hA5A5_3C3C);
        cfg_fmt = 1'b1; cfg_en = 1'b1;
        sdv = '0; wsv = '0;
        for (int i = 0; i < FW; i++) begin
            sck_step(1'b0, s, w);
            sdv[FW - 1 - i] = s;
            wsv[i] = w;
        end
        chk("lj_sd_word", sdv, 32'hA5A5_3C3C);
        chk("lj_ws_mask", wsv, 32'hFFFF_0000);

        // Underrun
        cfg_en = 1'b0;
        tick();
        cfg_en = 1'b1;
        sck_step(1'b0, s, w);
        chk("ur_set_on_empty_load", 32'(ro_fifo_underrun), 32'd1);
        trig_fifo_underrun = 1'b1;
        tick();
        trig_fifo_underrun = 1'b0;
        chk("ur_cleared", 32'(ro_fifo_underrun), 32'd0);
        sdv = '0;
        for (int i = 1; i < FW; i++) begin
            sck_step(1'b0, s, w);
            sdv[i] = s;
        end
        chk("ur_sd_zero", sdv, 32'd0);
        sck_step(1'b1, s, w);
        chk("ur_set_beats_clear", 32'(ro_fifo_underrun), 32'd1);

        // Overrun
        cfg_en = 1'b0;
        tick();
        filt_rts = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            filt_data = 32'hC0DE_0000 + 32'(i);
            tick();
            if (i == 8) begin
                chk("or_level_full", 32'(fifo_level),      32'd8);
                chk("or_rtr_low",    32'(filt_rtr),        32'd0);
                chk("or_not_yet",    32'(ro_fifo_overrun), 32'd0);
            end
            if (i == 9) chk("or_set", 32'(ro_fifo_overrun), 32'd1);
        end
        filt_rts = 1'b0;
        trig_fifo_overrun = 1'b1;
        tick();
        trig_fifo_overrun = 1'b0;
        chk("or_cleared", 32'(ro_fifo_overrun), 32'd0);
        chk("or_level_kept", 32'(fifo_level), 32'd8);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Mono
        push_word(32'h1234_FFFF);
        cfg_mono = 1'b1; cfg_fmt = 1'b1; cfg_en = 1'b1;
        sdv = '0;
        for (int i = 0; i < FW; i++) begin
            sck_step(1'b0, s, w);
            sdv[FW - 1 - i] = s;
        end
        chk("mono_sd_word", sdv, 32'h1234_1234);
        sck_step(1'b0, s, w);
        chk("mono_then_underrun", 32'(ro_fifo_underrun), 32'd1);

        // Reset in the middle of a frame
        cfg_en = 1'b0;
        tick();
        push_word(32'hFFFF_FFFF);
        push_word(32'h1111_1111);
        push_word(32'h2222_2222);
        push_word(32'h3333_3333);
        cfg_en = 1'b1;
        for (int i = 0; i < 8; i++) sck_step(1'b0, s, w);
        chk("mid_level3", 32'(fifo_level), 32'd3);
        chk("mid_sd_one", 32'(s), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_sd",    32'(i2so_sd),          32'd0);
        chk("arst_ws",    32'(i2so_ws),          32'd0);
        chk("arst_level", 32'(fifo_level),       32'd0);
        chk("arst_ur",    32'(ro_fifo_underrun), 32'd0);
        chk("arst_or",    32'(ro_fifo_overrun),  32'd0);
        tick();
        rst = 1'b0;
        tick();
        sck_step(1'b0, s, w);
        chk("post_rst_underrun", 32'(ro_fifo_underrun), 32'd1);
        tick();

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
